// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

    localparam int unsigned APB_DW = 32;
    localparam int unsigned AHB_AW = 32;
    localparam int unsigned SLOT_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_SETUP  = 2'd2,
        ST_ACCESS = 2'd3
    } state_t;

    // Address-phase command latched when a transfer is accepted.
    typedef struct packed {
        logic [AHB_AW-1:0] addr;
        logic              write;
        logic [SLOT_W-1:0] slot;
    } apb_cmd_t;

endpackage

// File: rtl/apb_rdata_mux.sv
// Selects one slave's read-data slice; zero when disabled or the slot is unmapped.
module apb_rdata_mux
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV = 4
) (
    input  logic                     i_en,
    input  logic [SLOT_W-1:0]        i_slot,
    input  logic [NSLV*APB_DW-1:0]   i_rdata,
    output logic [APB_DW-1:0]        o_rdata_c
);

    always_comb begin
        o_rdata_c = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (i_en && (i_slot == SLOT_W'(k))) begin
                o_rdata_c = i_rdata[k*APB_DW +: APB_DW];
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite single-transfer to APB2 initiator: one SETUP plus one ACCESS per transfer,
// one-hot PSEL over NSLV 4 KB slots.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SEL_LSB = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic [31:0]             PADDR,
    output logic                    PWRITE,
    output logic [NSLV-1:0]         PSEL,
    output logic                    PENABLE,
    output logic [31:0]             PWRDATA,
    input  logic [NSLV*32-1:0]      PRDDATA
);

    state_t            r_state;
    state_t            w_next;
    apb_cmd_t          r_cmd;
    logic [31:0]       r_pwrdata;
    logic [NSLV-1:0]   r_psel;
    logic              r_penable;
    logic              r_hreadyout;

    logic              w_accept;
    logic              w_start;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic [NSLV-1:0]   w_psel_nxt;
    logic [31:0]       w_hrdata;
    logic              w_unused;

    assign w_unused = ^{HSIZE, HTRANS[0]};
    assign w_accept = HSEL & HTRANS[1] & HREADY;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; a new transfer is only taken in IDLE or in the last (ACCESS) cycle
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    w_next  = HWRITE ? ST_WDATA : ST_SETUP;
                end
            end
            ST_WDATA:  w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    w_next  = HWRITE ? ST_WDATA : ST_SETUP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_slot_nxt = w_start ? HADDR[SEL_LSB +: SLOT_W] : r_cmd.slot;

    // One-hot select for the upcoming cycle; unmapped slots decode to all zero
    always_comb begin
        w_psel_nxt = '0;
        if ((w_next == ST_SETUP) || (w_next == ST_ACCESS)) begin
            for (int unsigned k = 0; k < NSLV; k++) begin
                if (w_slot_nxt == SLOT_W'(k)) begin
                    w_psel_nxt[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= '0;
            r_pwrdata   <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
        end else begin
            if (w_start) begin
                r_cmd.addr  <= {HADDR[31:2], 2'b00};
                r_cmd.write <= HWRITE;
                r_cmd.slot  <= HADDR[SEL_LSB +: SLOT_W];
            end
            if (r_state == ST_WDATA) begin
                r_pwrdata <= HWDATA;
            end
            r_psel      <= w_psel_nxt;
            r_penable   <= (w_next == ST_ACCESS);
            r_hreadyout <= (w_next == ST_IDLE) || (w_next == ST_ACCESS);
        end
    end

    apb_rdata_mux #(
        .NSLV (NSLV)
    ) u_rdata_mux (
        .i_en      ((r_state == ST_ACCESS) && !r_cmd.write),
        .i_slot    (r_cmd.slot),
        .i_rdata   (PRDDATA),
        .o_rdata_c (w_hrdata)
    );

    assign HREADYOUT = r_hreadyout;
    assign HRDATA    = w_hrdata;
    assign HRESP     = 1'b0;
    assign PADDR     = r_cmd.addr;
    assign PWRITE    = r_cmd.write;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRDATA   = r_pwrdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: transaction-timeline model with per-cycle compare,
// plus directed literal checks of the documented scenarios.
module tb_ahb_apb_bridge;

    localparam int NSLV = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               HSEL = 1'b0;
    logic [31:0]        HADDR = '0;
    logic [1:0]         HTRANS = 2'b00;
    logic               HWRITE = 1'b0;
    logic [2:0]         HSIZE = 3'b010;
    logic [31:0]        HWDATA = '0;
    logic               HREADY = 1'b1;
    logic               HREADYOUT;
    logic [31:0]        HRDATA;
    logic               HRESP;
    logic [31:0]        PADDR;
    logic               PWRITE;
    logic [NSLV-1:0]    PSEL;
    logic               PENABLE;
    logic [31:0]        PWRDATA;
    logic [NSLV*32-1:0] PRDDATA;

    logic [31:0] slv0_reg = '0;
    logic [31:0] prd1 = 32'hDEAD_BEEF;
    logic [31:0] next_wdata = '0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign PRDDATA = {32'hC0DE_0003, 32'hC0DE_0002, prd1, slv0_reg};

    ahb_apb_bridge #(.NSLV(NSLV), .SEL_LSB(12)) dut (
        .clk(clk), .rst_n(rst_n), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWRDATA(PWRDATA),
        .PRDDATA(PRDDATA)
    );

    // Behavioural slave 0: a plain register committed at the end of ACCESS
    always @(posedge clk) begin
        if (PSEL[0] && PENABLE && PWRITE) slv0_reg <= PWRDATA;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    typedef struct {
        logic [NSLV-1:0] psel;
        logic            pen;
        logic            rdy;
        logic            rd;
        logic            wcap;
        logic [3:0]      slot;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    logic [31:0] m_paddr = '0;
    logic        m_pwrite = 1'b0;
    logic [31:0] m_pwdata = '0;

    function automatic rec_t mk(logic [NSLV-1:0] psel, logic pen, logic rdy,
                                logic rd, logic wcap, logic [3:0] slot);
        rec_t r;
        r.psel = psel; r.pen = pen; r.rdy = rdy; r.rd = rd; r.wcap = wcap; r.slot = slot;
        return r;
    endfunction

    function automatic logic [NSLV-1:0] onehot(logic [3:0] slot);
        logic [NSLV-1:0] v = '0;
        if (int'(slot) < NSLV) v[slot] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = mk('0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
        end else begin
            logic [3:0] s;
            if (cur.wcap) m_pwdata = HWDATA;
            // A transfer is taken whenever the bridge shows ready and the bus offers one
            if (cur.rdy && HSEL && HTRANS[1] && HREADY) begin
                s = HADDR[15:12];
                m_paddr  = {HADDR[31:2], 2'b00};
                m_pwrite = HWRITE;
                if (HWRITE) q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b1, s));
                q.push_back(mk(onehot(s), 1'b0, 1'b0, 1'b0, 1'b0, s));
                q.push_back(mk(onehot(s), 1'b1, 1'b1, !HWRITE, 1'b0, s));
            end
            cur = (q.size() != 0) ? q.pop_front() : mk('0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_hr;
            exp_hr = '0;
            if (cur.rd && int'(cur.slot) < NSLV) exp_hr = PRDDATA[int'(cur.slot)*32 +: 32];
            chk("m_hreadyout", 32'(HREADYOUT), 32'(cur.rdy));
            chk("m_psel",      32'(PSEL),      32'(cur.psel));
            chk("m_penable",   32'(PENABLE),   32'(cur.pen));
            chk("m_hrdata",    HRDATA,         exp_hr);
            chk("m_hresp",     32'(HRESP),     32'd0);
            chk("m_paddr",     PADDR,          m_paddr);
            chk("m_pwrite",    32'(PWRITE),    32'(m_pwrite));
            chk("m_pwrdata",   PWRDATA,        m_pwdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; next_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = next_wdata;
    endtask

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic b2b; } vec_t;
    vec_t vecs[8];

    logic [4:0] pen_pat;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'h1111_2222, 1'b1};
        vecs[1] = '{1'b0, 32'h0000_0014, 32'h0,         1'b1};
        vecs[2] = '{1'b0, 32'h0000_1000, 32'h0,         1'b0};
        vecs[3] = '{1'b1, 32'h0000_2ABC, 32'hA5A5_0F0F, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_3004, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 32'h0000_9000, 32'h7777_0000, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_B000, 32'h0,         1'b1};
        vecs[7] = '{1'b1, 32'h0000_0FFF, 32'h0000_0006, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_psel",      32'(PSEL),      32'd0);
        chk("rst_paddr",     PADDR,          32'd0);
        chk("rst_hrdata",    HRDATA,         32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Read slot 1
        send(1'b0, 32'h0000_1008, 32'h0);
        tick();
        chk("rd1_psel_c1",    32'(PSEL),      32'h2);
        chk("rd1_paddr_c1",   PADDR,          32'h0000_1008);
        chk("rd1_penable_c1", 32'(PENABLE),   32'd0);
        chk("rd1_hrdy_c1",    32'(HREADYOUT), 32'd0);
        tick();
        chk("rd1_penable_c2", 32'(PENABLE),   32'd1);
        chk("rd1_hrdy_c2",    32'(HREADYOUT), 32'd1);
        chk("rd1_hrdata_c2",  HRDATA,         32'hDEAD_BEEF);
        tick();

        // Write 6 to 0x4 (slot 0)
        send(1'b1, 32'h0000_0004, 32'h0000_0006);
        tick();
        chk("wr_hrdy_c1",    32'(HREADYOUT), 32'd0);
        tick();
        chk("wr_hrdy_c2",    32'(HREADYOUT), 32'd0);
        chk("wr_pwrdata_c2", PWRDATA,        32'h6);
        tick();
        chk("wr_penable_c3", 32'(PENABLE),   32'd1);
        chk("wr_hrdy_c3",    32'(HREADYOUT), 32'd1);
        tick();
        chk("wr_slave_bits", 32'(slv0_reg[2:0]), 32'b110);

        // Back-to-back write then read on slot 0
        send(1'b1, 32'h0000_0008, 32'h0000_005A);
        tick(); pen_pat[4] = PENABLE;
        tick(); pen_pat[3] = PENABLE;
        tick(); pen_pat[2] = PENABLE;
        send(1'b0, 32'h0000_0008, 32'h0);
        tick(); pen_pat[1] = PENABLE;
        chk("b2b_no_idle", 32'(HREADYOUT), 32'd0);
        tick(); pen_pat[0] = PENABLE;
        chk("b2b_pen_pat", 32'(pen_pat), 32'b00101);
        chk("b2b_hrdata",  HRDATA,       32'h0000_005A);
        tick();

        // Unmapped read
        send(1'b0, 32'h0000_7000, 32'h0);
        tick();
        chk("um_psel_c1",  32'(PSEL),      32'd0);
        chk("um_hrdy_c1",  32'(HREADYOUT), 32'd0);
        tick();
        chk("um_psel_c2",  32'(PSEL),      32'd0);
        chk("um_hrdata",   HRDATA,         32'd0);
        chk("um_hresp",    32'(HRESP),     32'd0);
        chk("um_hrdy_c2",  32'(HREADYOUT), 32'd1);
        tick();

        // Non-transfers: BUSY, HSEL low, HREADY low
        HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_1000;
        tick();
        chk("busy_psel", 32'(PSEL), 32'd0);
        chk("busy_hrdy", 32'(HREADYOUT), 32'd1);
        HSEL = 1'b0; HTRANS = 2'b10; HADDR = 32'h0000_1000;
        tick();
        chk("nosel_psel", 32'(PSEL), 32'd0);
        chk("nosel_hrdy", 32'(HREADYOUT), 32'd1);
        send(1'b0, 32'h0000_1000, 32'h0); HREADY = 1'b0;
        tick();
        HREADY = 1'b1;
        chk("nordy_psel", 32'(PSEL), 32'd0);
        tick();

        // Directed vector table, mix of back-to-back and spaced transfers
        foreach (vecs[i]) begin
            send(vecs[i].w, vecs[i].a, vecs[i].d);
            repeat (vecs[i].w ? 3 : 2) tick();
            if (!vecs[i].b2b) tick();
        end
        tick();
        chk("vec_slave0", slv0_reg, 32'h0000_0006);

        // Reset during SETUP of a write
        send(1'b1, 32'h0000_0000, 32'h0000_0077);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_psel",    32'(PSEL),      32'd0);
        chk("arst_penable", 32'(PENABLE),   32'd0);
        chk("arst_paddr",   PADDR,          32'd0);
        chk("arst_pwrite",  32'(PWRITE),    32'd0);
        chk("arst_pwrdata", PWRDATA,        32'd0);
        chk("arst_hrdy",    32'(HREADYOUT), 32'd1);
        chk("arst_hrdata",  HRDATA,         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_slave", slv0_reg, 32'h0000_0006);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
